// File: rtl/mesh_pkg.sv
// Mesh-wide types and constants shared by the router stages.
// Defines the Packet layout, the largest legal port count and the port-index map.
package Mesh;

   localparam int MAX_PORTS = 8;

   localparam int PORT_N     = 0;
   localparam int PORT_E     = 1;
   localparam int PORT_S     = 2;
   localparam int PORT_W     = 3;
   localparam int PORT_LOCAL = 4;

   typedef struct packed {
      logic [2:0]  dst_x;
      logic [2:0]  dst_y;
      logic [2:0]  src_port;
      logic [22:0] payload;
   } Packet;

endpackage : Mesh

// File: rtl/router_output_if.sv
// Bundle between the input stages, the output stage and the outgoing link.
// master = the router_output instance, slave = its surrounding environment.
interface router_output_if
   import Mesh::*;
#(
   parameter int NUM_INPUTS = 5
);

   logic [NUM_INPUTS-1:0] req;
   Packet                 packet_in [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] grant;
   Packet                 packet_out;
   logic                  valid;
   logic                  ready;

   modport master (
      input  req, packet_in, ready,
      output grant, packet_out, valid
   );

   modport slave (
      output req, packet_in, ready,
      input  grant, packet_out, valid
   );

endinterface : router_output_if

// File: rtl/router_output_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit after last_i, wrapping modulo N.
// The priority pointer is owned by the caller.
module rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic             enable_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] winner_o
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
      gnt_o    = '0;
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IDX_W'((int'(last_i) + k) % N);
         if (enable_i && !found && req_i[idx]) begin
            found       = 1'b1;
            gnt_o[idx]  = 1'b1;
            winner_o    = idx;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/router_output.sv
// Router output port: round-robin pick among NUM_INPUTS requesters into a one-entry link register.
// Define ROUTER_OUTPUT_STATS_EN to add saturating pkt_count / stall_count outputs.
module router_output
   import Mesh::*;
#(
   parameter int NUM_INPUTS = 5,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   router_output_if.master    bus
`ifdef ROUTER_OUTPUT_STATS_EN
   ,
   output logic [CNT_W-1:0]   pkt_count,
   output logic [CNT_W-1:0]   stall_count
`endif
);

   localparam int IDX_W = $clog2(NUM_INPUTS);

   // valid is the buffer state bit itself.
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_PORTS || CNT_W < 1) begin : g_param_check
      $error("router_output: NUM_INPUTS must be 2..%0d and CNT_W >= 1", MAX_PORTS);
   end

   logic [0:0]            state_q, state_d;
   Packet                 packet_q, packet_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic [IDX_W-1:0]      winner;
   logic [NUM_INPUTS-1:0] gnt;
   logic                  can_accept;
   logic                  arb_en;
   logic                  any_grant;

   // Gating with rst_n keeps grant low for the whole reset, not just after the first edge.
   assign can_accept = (state_q == ST_EMPTY) || bus.ready;
   assign arb_en     = can_accept && rst_n;

   rr_arbiter #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i    (bus.req),
      .enable_i (arb_en),
      .last_i   (last_q),
      .gnt_o    (gnt),
      .winner_o (winner)
   );

   assign any_grant = |gnt;

   always_comb begin
      state_d  = state_q;
      packet_d = packet_q;
      last_d   = last_q;
      if (any_grant) begin
         state_d  = ST_FULL;
         packet_d = bus.packet_in[winner];
         last_d   = winner;
      end else if (state_q == ST_FULL && bus.ready) begin
         state_d  = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: packet_q is a single datapath register, not a memory, so it is cleared to keep packet_out at 0 in reset.
         state_q  <= ST_EMPTY;
         packet_q <= '0;
         last_q   <= IDX_W'(NUM_INPUTS - 1);
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         packet_q <= packet_d;
         last_q   <= last_d;
      end
   end

   assign bus.grant      = gnt;
   assign bus.packet_out = packet_q;
   assign bus.valid      = (state_q == ST_FULL);

`ifdef ROUTER_OUTPUT_STATS_EN
   logic [CNT_W-1:0] pkt_count_q;
   logic [CNT_W-1:0] stall_count_q;
   logic             stalled;

   assign stalled = (state_q == ST_FULL) && !bus.ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count_q   <= '0;
         stall_count_q <= '0;
      end else begin
         if (any_grant && (pkt_count_q != '1)) begin
            pkt_count_q <= pkt_count_q + CNT_W'(1);
         end
         if (stalled && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
         end
      end
   end

   assign pkt_count   = pkt_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule : router_output

// File: tb/tb_router_output.sv
// Directed bench for router_output with a packet scoreboard; checks stats when ROUTER_OUTPUT_STATS_EN is set.
module tb_router_output;
   import Mesh::*;

   localparam int NI = 5;
   localparam int CW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   router_output_if #(.NUM_INPUTS(NI)) bus ();

`ifdef ROUTER_OUTPUT_STATS_EN
   logic [CW-1:0] pkt_count;
   logic [CW-1:0] stall_count;
`endif

   router_output #(
      .NUM_INPUTS (NI),
      .CNT_W      (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ROUTER_OUTPUT_STATS_EN
      ,
      .pkt_count   (pkt_count),
      .stall_count (stall_count)
`endif
   );

   int    checks   = 0;
   int    errors   = 0;
   int    seq      = 0;
   int    grants_m = 0;
   int    stalls_m = 0;
   Packet sb [$];
   logic  exp_valid;
   Packet exp_pkt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic Packet mk(input int port, input int s);
      Packet p;
      p.dst_x    = 3'(s);
      p.dst_y    = 3'(s >> 3);
      p.src_port = 3'(port);
      p.payload  = 23'(s * 37 + port * 101 + 1);
      return p;
   endfunction

   function automatic int sat(input int v);
      return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
   endfunction

   // One cycle: drive at negedge, check grant before the edge, check link outputs after it.
   task automatic step(input logic [NI-1:0] r, input logic rdy,
                       input logic [NI-1:0] exp_g, input string tag);
      @(negedge clk);
      seq++;
      for (int i = 0; i < NI; i++) bus.packet_in[i] = mk(i, seq);
      bus.req   = r;
      bus.ready = rdy;
      #1;
      check({tag, " grant"}, 64'(bus.grant), 64'(exp_g));
      if (exp_valid && !rdy) stalls_m++;
      if (exp_g != '0) begin
         grants_m++;
         for (int i = 0; i < NI; i++) if (exp_g[i]) sb.push_back(mk(i, seq));
      end
      @(posedge clk);
      #1;
      if (exp_g != '0) begin
         if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'(sb.size()), 64'(1));
         end else begin
            exp_pkt = sb.pop_front();
         end
         exp_valid = 1'b1;
      end else if (exp_valid && rdy) begin
         exp_valid = 1'b0;
      end
      check({tag, " valid"},      64'(bus.valid),      64'(exp_valid));
      check({tag, " packet_out"}, 64'(bus.packet_out), 64'(exp_pkt));
   endtask

   initial begin
      exp_valid = 1'b0;
      exp_pkt   = '0;
      bus.req   = '1;
      bus.ready = 1'b1;
      for (int i = 0; i < NI; i++) bus.packet_in[i] = mk(i, 0);

      // Reset held with every input requesting.
      #12;
      check("rst grant",      64'(bus.grant),      64'(0));
      check("rst valid",      64'(bus.valid),      64'(0));
      check("rst packet_out", 64'(bus.packet_out), 64'(0));
      @(posedge clk);
      #1;
      check("rst grant after edge", 64'(bus.grant), 64'(0));
      check("rst valid after edge", 64'(bus.valid), 64'(0));
      @(negedge clk);
      bus.req = '0;
      rst_n   = 1'b1;

      // Fairness: all inputs requesting, served in order starting at input 0.
      for (int k = 0; k < 10; k++) step('1, 1'b1, NI'(1) << (k % NI), "fair");

      // Backpressure: packet A (from input 4) held while ready is low.
      for (int k = 0; k < 4; k++) step(5'b00100, 1'b0, 5'b00000, "stall");
      step(5'b00100, 1'b1, 5'b00100, "resume");

      // Wrap and skip around the pointer.
      step(5'b01000, 1'b1, 5'b01000, "ptr3");
      step(5'b00101, 1'b1, 5'b00001, "wrap");
      step(5'b00100, 1'b1, 5'b00100, "skip");

      // Drain to empty; ready is ignored when empty, and an empty buffer accepts with ready low.
      step(5'b00000, 1'b1, 5'b00000, "drain");
      step(5'b00000, 1'b1, 5'b00000, "idle");
      step(5'b00010, 1'b0, 5'b00010, "empty_accept");

      // Async reset between edges with packet B buffered.
      @(negedge clk);
      bus.req = 5'b00110;
      #2;
      rst_n = 1'b0;
      #1;
      check("async valid",      64'(bus.valid),      64'(0));
      check("async packet_out", 64'(bus.packet_out), 64'(0));
      check("async grant",      64'(bus.grant),      64'(0));
      exp_valid = 1'b0;
      exp_pkt   = '0;
      sb.delete();
      grants_m  = 0;
      stalls_m  = 0;
      bus.req   = '0;
      #1;
      rst_n = 1'b1;
      step(5'b00110, 1'b1, 5'b00010, "post_rst_prio");

      // Long run of grants followed by three stall cycles.
      for (int k = 0; k < 20; k++) step('1, 1'b1, NI'(1) << ((2 + k) % NI), "run");
      for (int k = 0; k < 3; k++)  step('1, 1'b0, 5'b00000, "stall2");

`ifdef ROUTER_OUTPUT_STATS_EN
      check("pkt_count saturated", 64'(pkt_count),   64'(sat(grants_m)));
      check("stall_count",         64'(stall_count), 64'(sat(stalls_m)));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_router_output

// File: doc/router_output.md
Name: router_output

Overview:
- Output port stage of the mesh router, directly downstream of the per-port input stages.
- Collects requests from NUM_INPUTS input stages and picks one per cycle by round-robin arbitration.
- Grants the winner and captures its packet into a single-entry output register that drives the outgoing link with a valid/ready handshake.
- One instance is built per router output direction.

Parameters:
- NUM_INPUTS, 5, number of requesting input stages (N, E, S, W, local); legal range 2..8.
- CNT_W, 16, width of statistics counters; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_INPUTS  req[i]=1: input stage i holds a packet destined for this output.
- packet_in  input  NUM_INPUTS x Mesh::Packet  packet offered by each input stage; valid only while the matching req bit is high.
- grant  output  NUM_INPUTS  one-hot or zero, combinational; grant[i]=1 means packet_in[i] is captured on this edge.
- packet_out  output  Mesh::Packet  buffered packet toward the link.
- valid  output  1  packet_out holds a packet.
- ready  input  1  downstream accepts packet_out this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - valid=0 and packet_out=0.
  - Round-robin pointer last=NUM_INPUTS-1, so input 0 has top priority first.
  - grant=0 while rst_n is low.
  - Reset mid-transfer discards the buffered packet; no partial state survives.
- Buffer states:
  - EMPTY (valid=0) and FULL (valid=1); valid is the state bit.
  - can_accept = !valid || ready.
- Arbitration (combinational):
  - When can_accept=1 and at least one req bit is set, the winner is the first set req bit scanning last+1, last+2, ... with wrap modulo NUM_INPUTS.
  - grant = one-hot winner; otherwise grant=0.
  - A req bit on an input not granted must be held by the input stage; this block never drops a request.
- Capture (on the edge where grant≠0):
  - packet_out <= packet_in[winner]
  - valid <= 1
  - last <= winner
- Drain: valid=1 and ready=1 with no grant -> valid <= 0 (FULL->EMPTY).
- Simultaneous drain and capture: valid stays 1 and packet_out is replaced, giving 1 packet/cycle sustained throughput.
- Stall: valid=1 and ready=0 -> grant=0; packet_out and valid are held stable (no change until accepted).
- Latency: a packet granted in cycle t is presented with valid=1 in cycle t+1.
- Pointer behaviour:
  - The pointer moves only on a grant.
  - A single persistent requester is granted back-to-back.
  - N persistent requesters are each served once every N grants.
- ready while valid=0 is ignored.

Optional Feature:
- Macro: ROUTER_OUTPUT_STATS_EN.
- When defined, adds two outputs:
  - pkt_count (CNT_W): increments on every grant.
  - stall_count (CNT_W): increments each cycle with valid=1 and ready=0.
- Both counters saturate at all-ones and reset to 0 on rst_n.
- When not defined, neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Mesh package holds:
  - the Mesh::Packet typedef;
  - the MAX_PORTS=8 constant;
  - port-index constants PORT_N/E/S/W/LOCAL.
- Natural sub-module rr_arbiter (parameter N):
  - inputs: req, enable, last;
  - outputs: one-hot gnt, encoded winner index.
  - Purely combinational; the pointer register lives in router_output.

Test Plan:
- Reset: hold rst_n=0 with req=5'b11111 -> grant=0, valid=0. Release rst_n, ready=1 -> first grant=5'b00001.
- Fairness: req=5'b11111 held, ready=1 for 10 cycles -> grant sequence 00001, 00010, 00100, 01000, 10000, 00001, ...; valid=1 from cycle 2 onward.
- Backpressure: capture packet A, then ready=0 for 4 cycles with req=5'b00100 -> grant=0 and packet_out=A stable. Raise ready -> same cycle grant=5'b00100; next cycle packet_out=input 2's packet.
- Wrap/skip: last=3, req=5'b00101 -> grant=5'b00001; next cycle with req=5'b00100 -> grant=5'b00100.
- Async reset mid-operation: valid=1 with packet B, drop rst_n between edges -> valid=0 immediately; after release the pointer is back to input-0 priority.
- Stats (ROUTER_OUTPUT_STATS_EN, CNT_W=4): 20 grants -> pkt_count=15 (saturated); 3 stall cycles -> stall_count=3.
